// File: rtl/univ_reg.sv
// univ_reg: WIDTH-bit universal register with synchronous clear, enable and
// eight modes (hold, load, shift, rotate, count up/down) plus a wrap pulse.
module univ_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             wrap
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROTL = 3'b100;
    localparam logic [2:0] MODE_ROTR = 3'b101;
    localparam logic [2:0] MODE_INC  = 3'b110;
    localparam logic [2:0] MODE_DEC  = 3'b111;

    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic [WIDTH-1:0] q_next_s;
    logic             wrap_next_s;

    // Next-state selection by mode; wrap only pulses on a count rollover.
    always_comb begin
        q_next_s    = q_r;
        wrap_next_s = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD: q_next_s = q_r;
                MODE_LOAD: q_next_s = d;
                MODE_SHL:  q_next_s = {q_r[WIDTH-2:0], sin_r};
                MODE_SHR:  q_next_s = {sin_l, q_r[WIDTH-1:1]};
                MODE_ROTL: q_next_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                MODE_ROTR: q_next_s = {q_r[0], q_r[WIDTH-1:1]};
                MODE_INC: begin
                    q_next_s    = q_r + ONE;
                    wrap_next_s = (q_r == ALL_ONES);
                end
                MODE_DEC: begin
                    q_next_s    = q_r - ONE;
                    wrap_next_s = (q_r == ZERO);
                end
                default: begin
                    q_next_s    = q_r;
                    wrap_next_s = 1'b0;
                end
            endcase
        end else begin
            q_next_s    = q_r;
            wrap_next_s = 1'b0;
        end
    end

    // State register; clear dominates enable and mode.
    always_ff @(posedge clk) begin
        if (clr) begin
            q_r    <= RESET_VAL;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_next_s;
            wrap_r <= wrap_next_s;
        end
    end

    assign q      = q_r;
    assign wrap   = wrap_r;
    assign sout_l = q_r[WIDTH-1];
    assign sout_r = q_r[0];

endmodule

// File: tb/tb_univ_reg.sv
// Self-checking bench for univ_reg: directed 8-bit steps with a scoreboard
// queue, then INC rollover sweeps at WIDTH=2 and WIDTH=16.
module tb_univ_reg;

    typedef struct {
        string       tag;
        logic [15:0] q;
        logic        wrap;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr8, en8, sr8, sl8;
    logic [2:0] mode8;
    logic [7:0] d8, q8;
    logic       sol8, sor8, wrap8;

    logic       clr2, en2, sr2, sl2;
    logic [2:0] mode2;
    logic [1:0] d2, q2;
    logic       sol2, sor2, wrap2;

    logic        clr16, en16, sr16, sl16;
    logic [2:0]  mode16;
    logic [15:0] d16, q16;
    logic        sol16, sor16, wrap16;

    univ_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
        .clk(clk), .clr(clr8), .en(en8), .mode(mode8), .d(d8),
        .sin_r(sr8), .sin_l(sl8), .q(q8), .sout_l(sol8), .sout_r(sor8), .wrap(wrap8)
    );

    univ_reg #(.WIDTH(2)) dut2 (
        .clk(clk), .clr(clr2), .en(en2), .mode(mode2), .d(d2),
        .sin_r(sr2), .sin_l(sl2), .q(q2), .sout_l(sol2), .sout_r(sor2), .wrap(wrap2)
    );

    univ_reg #(.WIDTH(16)) dut16 (
        .clk(clk), .clr(clr16), .en(en16), .mode(mode16), .d(d16),
        .sin_r(sr16), .sin_l(sl16), .q(q16), .sout_l(sol16), .sout_r(sor16), .wrap(wrap16)
    );

    localparam logic [2:0] HOLD = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] SHL  = 3'b010;
    localparam logic [2:0] SHR  = 3'b011;
    localparam logic [2:0] ROTL = 3'b100;
    localparam logic [2:0] ROTR = 3'b101;
    localparam logic [2:0] INC  = 3'b110;
    localparam logic [2:0] DEC  = 3'b111;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock on the 8-bit instance: drive, queue the expectation, compare after the edge.
    task automatic step8(input string tag, input logic c, input logic e, input logic [2:0] m,
                         input logic [7:0] dv, input logic sr, input logic sl,
                         input logic [7:0] eq, input logic ew);
        exp_t x;
        exp_t y;
        clr8 = c; en8 = e; mode8 = m; d8 = dv; sr8 = sr; sl8 = sl;
        x.tag = tag; x.q = {8'h00, eq}; x.wrap = ew;
        sb.push_back(x);
        @(posedge clk);
        #1;
        y = sb.pop_front();
        chk({y.tag, ".q"},      {8'h00, q8},     y.q);
        chk({y.tag, ".wrap"},   {15'd0, wrap8},  {15'd0, y.wrap});
        chk({y.tag, ".sout_l"}, {15'd0, sol8},   {15'd0, y.q[7]});
        chk({y.tag, ".sout_r"}, {15'd0, sor8},   {15'd0, y.q[0]});
    endtask

    initial begin
        int        wraps;
        logic [1:0]  m2;
        logic [15:0] m16;
        exp_t x;
        exp_t y;

        clr2 = 1'b1; en2 = 1'b0; mode2 = HOLD; d2 = 2'd0; sr2 = 1'b0; sl2 = 1'b0;
        clr16 = 1'b1; en16 = 1'b0; mode16 = HOLD; d16 = 16'd0; sr16 = 1'b0; sl16 = 1'b0;

        // Reset dominates a pending load
        step8("rst0", 1'b1, 1'b1, LOAD, 8'hFF, 1'b0, 1'b0, 8'hA5, 1'b0);
        step8("rst1", 1'b1, 1'b1, LOAD, 8'hFF, 1'b0, 1'b0, 8'hA5, 1'b0);

        step8("load3c", 1'b0, 1'b1, LOAD, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0);
        for (int i = 0; i < 3; i++)
            step8("en0_hold", 1'b0, 1'b0, INC, 8'hFF, 1'b1, 1'b1, 8'h3C, 1'b0);
        step8("mode_hold", 1'b0, 1'b1, HOLD, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0);

        step8("load81", 1'b0, 1'b1, LOAD, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0);
        step8("shl",    1'b0, 1'b1, SHL,  8'hFF, 1'b0, 1'b0, 8'h02, 1'b0);
        step8("shr",    1'b0, 1'b1, SHR,  8'h00, 1'b0, 1'b1, 8'h81, 1'b0);
        step8("rotl",   1'b0, 1'b1, ROTL, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0);
        step8("rotr",   1'b0, 1'b1, ROTR, 8'h00, 1'b0, 1'b0, 8'h81, 1'b0);
        step8("shl_s1", 1'b0, 1'b1, SHL,  8'h00, 1'b1, 1'b0, 8'h03, 1'b0);
        step8("shr_s0", 1'b0, 1'b1, SHR,  8'hFF, 1'b1, 1'b0, 8'h01, 1'b0);
        step8("rotr_b", 1'b0, 1'b1, ROTR, 8'h00, 1'b0, 1'b0, 8'h80, 1'b0);

        step8("loadfe", 1'b0, 1'b1, LOAD, 8'hFE, 1'b0, 1'b0, 8'hFE, 1'b0);
        step8("inc1",   1'b0, 1'b1, INC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b0);
        step8("inc2",   1'b0, 1'b1, INC,  8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        step8("inc3",   1'b0, 1'b1, INC,  8'h00, 1'b0, 1'b0, 8'h01, 1'b0);
        step8("load01", 1'b0, 1'b1, LOAD, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0);
        step8("dec1",   1'b0, 1'b1, DEC,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        step8("dec2",   1'b0, 1'b1, DEC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1);
        step8("dec3",   1'b0, 1'b1, DEC,  8'h00, 1'b0, 1'b0, 8'hFE, 1'b0);

        // Clear on the same edge as a would-be wrap suppresses it
        step8("loadff",  1'b0, 1'b1, LOAD, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0);
        step8("clr_inc", 1'b1, 1'b1, INC,  8'h00, 1'b0, 1'b0, 8'hA5, 1'b0);
        step8("resume",  1'b0, 1'b1, INC,  8'h00, 1'b0, 1'b0, 8'hA6, 1'b0);
        step8("loadff2", 1'b0, 1'b1, LOAD, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0);
        step8("wrapinc", 1'b0, 1'b1, INC,  8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        step8("clr_aft", 1'b1, 1'b1, DEC,  8'h00, 1'b0, 1'b0, 8'hA5, 1'b0);
        step8("en0_wr",  1'b0, 1'b1, DEC,  8'h00, 1'b0, 1'b0, 8'hA4, 1'b0);

        // WIDTH=2 sweep: 5 INCs from 0
        @(posedge clk); #1;
        chk("w2.rst", {14'd0, q2}, 16'd0);
        clr2 = 1'b0; en2 = 1'b1; mode2 = INC;
        m2 = 2'd0; wraps = 0;
        for (int i = 0; i < 5; i++) begin
            x.tag = "w2.cnt"; x.wrap = (m2 == 2'd3); m2 = m2 + 2'd1; x.q = {14'd0, m2};
            sb.push_back(x);
            @(posedge clk); #1;
            y = sb.pop_front();
            chk({y.tag, ".q"}, {14'd0, q2}, y.q);
            chk({y.tag, ".wrap"}, {15'd0, wrap2}, {15'd0, y.wrap});
            if (wrap2 === 1'b1) wraps++;
        end
        en2 = 1'b0;
        chk("w2.wraps", wraps[15:0], 16'd1);
        chk("w2.final", {14'd0, q2}, 16'd1);

        // WIDTH=16 sweep: 65537 INCs from 0
        chk("w16.rst", q16, 16'd0);
        clr16 = 1'b0; en16 = 1'b1; mode16 = INC;
        m16 = 16'd0; wraps = 0;
        for (int i = 0; i < 65537; i++) begin
            x.tag = "w16.cnt"; x.wrap = (m16 == 16'hFFFF); m16 = m16 + 16'd1; x.q = m16;
            sb.push_back(x);
            @(posedge clk); #1;
            y = sb.pop_front();
            chk({y.tag, ".q"}, q16, y.q);
            chk({y.tag, ".wrap"}, {15'd0, wrap16}, {15'd0, y.wrap});
            if (wrap16 === 1'b1) wraps++;
        end
        en16 = 1'b0;
        chk("w16.wraps", wraps[15:0], 16'd1);
        chk("w16.final", q16, 16'd1);
        chk("sb.empty", sb.size() > 0 ? 16'd1 : 16'd0, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/univ_reg.md
# univ_reg

Parametrised universal register, the successor to the single-bit D flip-flop: a WIDTH-bit register with synchronous clear, enable, and eight operating modes (hold, parallel load, shift left/right, rotate left/right, count up/down). It serves as the general-purpose storage, shifter, and counter element in the lab datapaths. It replaces ad-hoc chains of single DFFs wherever a multi-bit register with more than plain load behaviour is needed.

## Interface
- WIDTH, 8, register width in bits; legal range ≥ 2
- RESET_VAL, 0, value loaded into q on clear; WIDTH bits

- clk  input  1  clock, all state changes on rising edge
- clr  input  1  synchronous reset, active-high; one clock; reset is synchronous and active-high
- en  input  1  operation enable; 0 = hold everything
- mode  input  3  operation select (encoding below)
- d  input  WIDTH  parallel load data
- sin_r  input  1  serial in, enters q[0] on shift left
- sin_l  input  1  serial in, enters q[WIDTH-1] on shift right
- q  output  WIDTH  register contents
- sout_l  output  1  = q[WIDTH-1] (combinational from q)
- sout_r  output  1  = q[0] (combinational from q)
- wrap  output  1  registered; 1 for one cycle after a count wraps

## Operation
- Priority at each rising clk: clr > en=0 > mode.
- clr=1: q <= RESET_VAL, wrap <= 0, regardless of en/mode.
- en=0 (clr=0): q holds, wrap <= 0.
- en=1, mode:
  - 000 HOLD: q holds; wrap <= 0
  - 001 LOAD: q <= d; wrap <= 0
  - 010 SHL: q <= {q[WIDTH-2:0], sin_r}; wrap <= 0
  - 011 SHR: q <= {sin_l, q[WIDTH-1:1]}; wrap <= 0
  - 100 ROTL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; wrap <= 0
  - 101 ROTR: q <= {q[0], q[WIDTH-1:1]}; wrap <= 0
  - 110 INC: q <= q + 1 modulo 2^WIDTH; wrap <= 1 iff q was all ones
  - 111 DEC: q <= q - 1 modulo 2^WIDTH; wrap <= 1 iff q was zero
- Arithmetic is unsigned, WIDTH bits, with no saturation; the carry beyond bit WIDTH-1 appears only in wrap.
- No internal state beyond q and wrap. No FSM: mode is sampled every cycle and may change cycle to cycle.

## Timing
- Latency 1 cycle: inputs sampled at rising edge N; q and wrap are valid after edge N.
- sout_l and sout_r follow q combinationally and change only after clock edges.
- wrap is a single-cycle pulse. Consecutive wraps (e.g. WIDTH-bit counting with continuous INC over 2^WIDTH cycles) produce one pulse per wrap.
- Reset mid-operation: clr asserted during INC/shift overrides on that edge; q = RESET_VAL and wrap = 0 after the edge. Operation resumes on the first edge with clr=0.
- Power-up: q and wrap are undefined until the first edge with clr=1. The bench must assert clr for at least 1 cycle at start.
- d, sin_l, and sin_r are ignored unless selected by mode.

## Test plan
- Reset: WIDTH=8, RESET_VAL=8'hA5; clr=1 for 2 cycles with mode=LOAD, d=8'hFF, en=1 -> q=8'hA5, wrap=0; clr dominates load.
- Load/hold: LOAD d=8'h3C -> q=8'h3C; then en=0 with mode=INC for 3 cycles -> q stays 8'h3C, wrap=0.
- Shift/rotate: q=8'h81; SHL sin_r=0 -> 8'h02; SHR sin_l=1 -> 8'h81; ROTL -> 8'h03; ROTR -> 8'h81; check sout_l/sout_r = q[7]/q[0] each cycle.
- Count wrap: LOAD 8'hFE, then INC x3 -> q=FF, 00, 01; wrap=0, 1, 0. LOAD 8'h01, then DEC x3 -> q=00, FF, FE; wrap=0, 1, 0.
- Reset mid-count: INC from 8'hFF with clr=1 on the same edge -> q=RESET_VAL, wrap=0 (the wrap pulse is suppressed).
- Parameter sweep: WIDTH=2 and WIDTH=16; run 2^WIDTH+1 consecutive INCs from 0 -> exactly one wrap pulse, q=1 at the end.
